// File: rtl/parity_stream_engine.sv
// Multi-lane XOR/XNOR parity engine on a valid/ready stream, with an optional
// ACC_LEN-beat frame accumulate mode and a single registered output entry.
module parity_stream_engine #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 2,
  parameter int ACC_LEN  = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic                      In_valid,
  output logic                      In_ready,
  input  logic [CHANNELS*WIDTH-1:0] In_data,
  input  logic [1:0]                Mode_in,
  output logic                      Out_valid,
  input  logic                      Out_ready,
  output logic [CHANNELS-1:0]       Out_parity,
  output logic [CNT_W-1:0]          Frame_cnt,
  output logic                      Busy
);

  localparam int BC_W = (ACC_LEN > 2) ? $clog2(ACC_LEN) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    MODE_XOR  = 2'b00,
    MODE_XNOR = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_XOR2 = 2'b11
  } mode_t;

  state_t              state, state_nx;
  logic [BC_W-1:0]     beat_cnt, beat_cnt_nx;
  logic [CHANNELS-1:0] acc, acc_nx;
  logic [CHANNELS-1:0] lane_par;
  logic [CHANNELS-1:0] parity_nx;
  logic                valid_nx;
  logic                free, accept, xfer, final_beat;
  mode_t               mode;

  assign mode = mode_t'(Mode_in);

  always_comb begin
    lane_par = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      lane_par[k] = ^In_data[k*WIDTH +: WIDTH];
    end
  end

  // The output entry can take a new result when empty or when draining this cycle.
  assign free       = !Out_valid || Out_ready;
  assign final_beat = (state == ACCUM) && (beat_cnt == BC_W'(ACC_LEN - 1));
  assign In_ready   = ((state == ACCUM) && !final_beat) ? 1'b1 : free;
  assign accept     = In_valid && In_ready;
  assign xfer       = Out_valid && Out_ready;
  assign Busy       = (state == ACCUM);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nx    = state;
    beat_cnt_nx = beat_cnt;
    acc_nx      = acc;
    parity_nx   = Out_parity;
    valid_nx    = Out_valid && !xfer;

    if (accept) begin
      unique case (state)
        IDLE: begin
          // The ACCUM state itself records the accumulate mode for the rest of the frame.
          unique case (mode)
            MODE_ACC: begin
              acc_nx      = lane_par;
              beat_cnt_nx = BC_W'(1);
              state_nx    = ACCUM;
            end
            MODE_XNOR: begin
              parity_nx = ~lane_par;
              valid_nx  = 1'b1;
            end
            default: begin
              parity_nx = lane_par;
              valid_nx  = 1'b1;
            end
          endcase
        end
        ACCUM: begin
          if (final_beat) begin
            parity_nx   = acc ^ lane_par;
            valid_nx    = 1'b1;
            beat_cnt_nx = '0;
            state_nx    = IDLE;
          end else begin
            acc_nx      = acc ^ lane_par;
            beat_cnt_nx = beat_cnt + BC_W'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      acc        <= '0;
      Out_valid  <= 1'b0;
      Out_parity <= '0;
      Frame_cnt  <= '0;
    end else begin
      state      <= state_nx;
      beat_cnt   <= beat_cnt_nx;
      acc        <= acc_nx;
      Out_valid  <= valid_nx;
      Out_parity <= parity_nx;
      if (xfer) begin
        Frame_cnt <= Frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_parity_stream_engine.sv
// Self-checking bench for parity_stream_engine: directed scenarios plus random
// traffic scored against a frame-level reference model.
module tb_parity_stream_engine;

  localparam int W  = 2;
  localparam int C  = 2;
  localparam int L  = 4;
  localparam int CW = 8;

  logic          Clock = 1'b0;
  logic          Reset_n = 1'b0;
  logic          In_valid = 1'b0;
  logic          In_ready;
  logic [C*W-1:0] In_data = '0;
  logic [1:0]    Mode_in = 2'b00;
  logic          Out_valid;
  logic          Out_ready = 1'b1;
  logic [C-1:0]  Out_parity;
  logic [CW-1:0] Frame_cnt;
  logic          Busy;

  parity_stream_engine #(.WIDTH(W), .CHANNELS(C), .ACC_LEN(L), .CNT_W(CW)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .In_valid(In_valid), .In_ready(In_ready),
    .In_data(In_data), .Mode_in(Mode_in), .Out_valid(Out_valid), .Out_ready(Out_ready),
    .Out_parity(Out_parity), .Frame_cnt(Frame_cnt), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending results, beats of the open frame, delivered count.
  logic [C-1:0]   res_q[$];
  logic [C*W-1:0] frame_q[$];
  bit             frame_on  = 0;
  logic [CW-1:0]  exp_cnt   = '0;
  bit             last_accept;
  int             results_made = 0;

  function automatic logic [C-1:0] beat_parity(input logic [C*W-1:0] d);
    logic [C-1:0] p;
    logic [W-1:0] lane;
    for (int k = 0; k < C; k++) begin
      lane = d[k*W +: W];
      p[k] = ($countones(lane) % 2) == 1;
    end
    return p;
  endfunction

  // Parity of a lane over a frame = odd total count of ones across all its beats.
  function automatic logic [C-1:0] frame_parity();
    logic [C-1:0]   p;
    logic [C*W-1:0] d;
    logic [W-1:0]   lane;
    int             ones;
    for (int k = 0; k < C; k++) begin
      ones = 0;
      foreach (frame_q[i]) begin
        d    = frame_q[i];
        lane = d[k*W +: W];
        ones += $countones(lane);
      end
      p[k] = (ones % 2) == 1;
    end
    return p;
  endfunction

  // Called at a negedge with inputs already driven; checks, updates the model,
  // and returns at the following negedge.
  task automatic cycle();
    bit exp_valid, exp_ready, xfer;
    #1;
    exp_valid = (res_q.size() != 0);
    exp_ready = (frame_on && frame_q.size() < L - 1) || !exp_valid || Out_ready;

    checks++;
    if (Out_valid !== exp_valid) begin
      failures++;
      $display("FAIL out_valid: got %b expected %b at %0t", Out_valid, exp_valid, $time);
    end
    if (exp_valid) begin
      checks++;
      if (Out_parity !== res_q[0]) begin
        failures++;
        $display("FAIL out_parity: got %b expected %b at %0t", Out_parity, res_q[0], $time);
      end
    end
    checks++;
    if (Busy !== frame_on) begin
      failures++;
      $display("FAIL busy: got %b expected %b at %0t", Busy, frame_on, $time);
    end
    checks++;
    if (In_ready !== exp_ready) begin
      failures++;
      $display("FAIL in_ready: got %b expected %b at %0t", In_ready, exp_ready, $time);
    end
    checks++;
    if (Frame_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL frame_cnt: got %0d expected %0d at %0t", Frame_cnt, exp_cnt, $time);
    end

    last_accept = 0;
    if (!Reset_n) begin
      res_q.delete();
      frame_q.delete();
      frame_on = 0;
      exp_cnt  = '0;
    end else begin
      xfer        = exp_valid && Out_ready;
      last_accept = In_valid && exp_ready;
      if (xfer) begin
        void'(res_q.pop_front());
        exp_cnt = exp_cnt + 1'b1;
      end
      if (last_accept) begin
        if (!frame_on) begin
          case (Mode_in)
            2'b10: begin
              frame_on = 1;
              frame_q.push_back(In_data);
            end
            2'b01: begin
              res_q.push_back(~beat_parity(In_data));
              results_made++;
            end
            default: begin
              res_q.push_back(beat_parity(In_data));
              results_made++;
            end
          endcase
        end else begin
          frame_q.push_back(In_data);
          if (frame_q.size() == L) begin
            res_q.push_back(frame_parity());
            results_made++;
            frame_q.delete();
            frame_on = 0;
          end
        end
      end
    end
    @(negedge Clock);
  endtask

  task automatic send_beat(input logic [C*W-1:0] d, input logic [1:0] m);
    bit done = 0;
    In_valid = 1'b1;
    In_data  = d;
    Mode_in  = m;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      done = last_accept;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL accept_timeout: beat %b not accepted within 20 cycles", d);
    end
    In_valid = 1'b0;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    cycle();
    cycle();
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    Out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      In_valid = 1'b1;
      In_data  = 4'($urandom);
      Mode_in  = 2'b10;
      Out_ready = 1'($urandom);
      cycle();
    end
    do_reset();
    In_valid  = 1'b0;
    Out_ready = 1'b0;
    #1;
    checks++;
    if ({Out_valid, Out_parity, Frame_cnt, Busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b parity=%b cnt=%0d busy=%b expected all 0",
               Out_valid, Out_parity, Frame_cnt, Busy);
    end
    checks++;
    if (In_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b expected 1", In_ready);
    end
    Out_ready = 1'b1;
    cycle();
  endtask

  task automatic test_xor();
    send_beat(4'b10_01, 2'b00);
    #1;
    checks++;
    if (Out_valid !== 1'b1 || Out_parity !== 2'b11) begin
      failures++;
      $display("FAIL xor_a: got valid=%b parity=%b expected 1/11", Out_valid, Out_parity);
    end
    send_beat(4'b11_00, 2'b00);
    #1;
    checks++;
    if (Out_valid !== 1'b1 || Out_parity !== 2'b00) begin
      failures++;
      $display("FAIL xor_b: got valid=%b parity=%b expected 1/00", Out_valid, Out_parity);
    end
    cycle();
  endtask

  task automatic test_xnor_stall();
    logic [CW-1:0] cnt0;
    send_beat(4'b11_01, 2'b01);
    Out_ready = 1'b0;
    cnt0      = exp_cnt;
    In_valid  = 1'b1;
    In_data   = 4'b00_01;
    Mode_in   = 2'b00;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (In_ready !== 1'b0 || Out_parity !== 2'b10 || Frame_cnt !== cnt0) begin
        failures++;
        $display("FAIL xnor_hold: got ready=%b parity=%b cnt=%0d expected 0/10/%0d",
                 In_ready, Out_parity, Frame_cnt, cnt0);
      end
      cycle();
    end
    In_valid  = 1'b0;
    Out_ready = 1'b1;
    cycle();
  endtask

  task automatic test_accum();
    int made0;
    made0 = results_made;
    send_beat(4'b01_01, 2'b10);
    send_beat(4'b01_00, 2'b00);
    #1;
    checks++;
    if (Busy !== 1'b1) begin
      failures++;
      $display("FAIL accum_busy: got %b expected 1", Busy);
    end
    send_beat(4'b00_11, 2'b01);
    send_beat(4'b10_01, 2'b11);
    // lane1: 1^1^0^1 = 1, lane0: 1^0^0^1 = 0
    #1;
    checks++;
    if (Out_valid !== 1'b1 || Out_parity !== 2'b10 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL accum_result: got valid=%b parity=%b busy=%b expected 1/10/0",
               Out_valid, Out_parity, Busy);
    end
    cycle();
    checks++;
    if (results_made - made0 != 1) begin
      failures++;
      $display("FAIL accum_count: got %0d results expected 1", results_made - made0);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_beat(4'b11_01, 2'b10);
    send_beat(4'b01_10, 2'b10);
    do_reset();
    send_beat(4'b01_01, 2'b00);
    #1;
    checks++;
    if (Out_valid !== 1'b1 || Out_parity !== 2'b11 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_frame: got valid=%b parity=%b busy=%b expected 1/11/0",
               Out_valid, Out_parity, Busy);
    end
    cycle();
  endtask

  task automatic test_wrap();
    do_reset();
    Out_ready = 1'b1;
    In_valid  = 1'b1;
    Mode_in   = 2'b00;
    for (int i = 0; i < 256; i++) begin
      In_data = 4'($urandom);
      cycle();
    end
    In_valid = 1'b0;
    cycle();
    checks++;
    if (Frame_cnt !== 8'd0) begin
      failures++;
      $display("FAIL frame_cnt_wrap: got %0d expected 0", Frame_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      In_valid  = ($urandom_range(0, 3) != 0);
      In_data   = 4'($urandom);
      Mode_in   = 2'($urandom);
      Out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    In_valid  = 1'b0;
    Out_ready = 1'b1;
    repeat (3) cycle();
    checks++;
    if (Out_valid !== 1'b0 || res_q.size() != 0) begin
      failures++;
      $display("FAIL random_drain: got valid=%b pending=%0d expected 0/0", Out_valid, res_q.size());
    end
  endtask

  initial begin
    @(negedge Clock);
    @(negedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
    test_reset();
    test_xor();
    test_xnor_stall();
    test_accum();
    test_reset_mid_frame();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
